// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler and optional auto-reload.
// Counts a programmed value down to zero, pulses tc on expiry and reports busy/done.
module countdown_timer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam int                PSC_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PSC_W-1:0]  PSC_MAX = PSC_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic [WIDTH-1:0] out_next;
    logic [PSC_W-1:0] psc, psc_next;
    logic             tc_next;
    logic             tick;

    assign tick = (psc == PSC_MAX);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values of the previous cycle regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out        <= '0;
            reload_reg <= '0;
            psc        <= '0;
            tc         <= 1'b0;
        end else begin
            state      <= state_next;
            out        <= out_next;
            reload_reg <= reload_next;
            psc        <= psc_next;
            tc         <= tc_next;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        out_next    = out;
        reload_next = reload_reg;
        psc_next    = psc;
        tc_next     = 1'b0;

        if (load) begin
            reload_next = load_val;
            out_next    = load_val;
            psc_next    = '0;
            state_next  = IDLE;
        end else if (stop && state == RUN) begin
            state_next = IDLE;
        end else if (start && state != RUN) begin
            out_next = reload_reg;
            psc_next = '0;
            if (reload_reg == '0) begin
                state_next = DONE;
                tc_next    = 1'b1;
            end else begin
                state_next = RUN;
            end
        end else if (state == RUN && enable) begin
            psc_next = tick ? '0 : psc + PSC_W'(1);
            if (tick) begin
                if (out > WIDTH'(1)) begin
                    out_next = out - WIDTH'(1);
                end else begin
                    // Expiry: reloading here keeps the period at reload_reg*DIV cycles.
                    tc_next = 1'b1;
                    if (auto_reload) begin
                        out_next = reload_reg;
                    end else begin
                        out_next   = '0;
                        state_next = DONE;
                    end
                end
            end
        end
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule
